ysyx_220053_decode_stage: RTL
=============================

YSYX_220053_DECODE_STAGE -- requirements
Module: ysyx_220053_decode_stage

Interface
REQ-001 Parameters SHALL be, one per line:
- XLEN, 64, datapath and immediate width (32 or 64).
- RV64, 1, W-op opcodes 0011011/0111011 legal when 1, illegal when 0.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  sync discard of all buffered entries.
- in_valid  in  1  upstream entry offered.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded entry offered.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  pc of the entry.
- out_op  out  7  instr[6:0].
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20].
- out_func3  out  3  instr[14:12].
- out_func7  out  7  instr[31:25].
- out_ext_op  out  3  0=I 1=U 2=S 3=B 4=J 5=R/none.
- out_imm  out  XLEN  sign-extended immediate.
- out_wen  out  1  rd write enable.
- out_ebreak  out  1  entry is ebreak.
- out_illegal  out  1  unsupported encoding.
- trap_done  out  1  one-cycle pulse when an ebreak entry leaves.

Function
REQ-003 Decoding SHALL be combinational on in_instr; results SHALL be registered at accept.
REQ-004 Opcode table (ext_op, wen): 0110111 and 0010111 (U,1); 1101111 (J,1); 1100111 (I,1); 1100011 (B,0); 0000011 (I,1); 0100011 (S,0); 0010011 (I,1); 0110011 (R,1); 0011011 (I,1) and 0111011 (R,1) only when RV64=1.
REQ-005 Immediates:
- I {instr[31:20]}
- U {instr[31:12],12'b0}
- S {instr[31:25],instr[11:7]}
- B {instr[31],instr[7],instr[30:25],instr[11:8],0}
- J {instr[31],instr[19:12],instr[20],instr[30:21],0}
- All sign-extended from instr[31] to XLEN.
- R/none: imm=0.
REQ-006 in_instr==32'h00100073 SHALL set ebreak=1, ext_op=0, wen=0, imm=1.
REQ-007 Encoding illegal when opcode absent from REQ-004/006, or when any of:
- jalr func3!=000
- branch func3 in {010,011}
- store func3>011
- load func3==111
- RV64=0 with W-op
Illegal entries: illegal=1, wen=0, ext_op=5, imm=0, ebreak=0.
REQ-008 Buffering SHALL be two entries: output register plus one skid register; no combinational path from out_ready to in_ready.
REQ-009 in_ready SHALL equal !skid_valid.
REQ-010 Accept SHALL occur on in_valid&&in_ready; leave SHALL occur on out_valid&&out_ready.
REQ-011 Accept when output empty or leaving: entry goes to output register, one cycle latency.
REQ-012 Accept while output full and not leaving: entry goes to skid register.
REQ-013 On leave with skid full: skid moves to output next cycle; skid becomes empty.
REQ-014 Order SHALL be strictly FIFO; no entry dropped or duplicated except by flush.
REQ-015 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 flush=1 SHALL clear both valids next edge, ignore same-cycle in_valid, and suppress trap_done.
REQ-017 trap_done SHALL pulse high in the cycle after a leave of an entry with out_ebreak=1.

Reset
REQ-018 rst_n low SHALL immediately clear out_valid, skid valid, trap_done and all out_* data to 0; in_ready=1 while rst_n low.
REQ-019 Reset mid-transfer SHALL discard both entries; first accept after release is the next in_instr.

Verification
REQ-020 addi x1,x0,-1 (32'hfff00093), out_ready=1 -> next cycle out_valid=1, rd=1, ext_op=0, wen=1, imm=64'hffffffffffffffff.
REQ-021 Back-to-back lui/sw/beq/jal with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts; order preserved; ext_op 1,2,3,4; wen 1,0,0,1.
REQ-022 32'h00100073 accepted, then leaves -> out_ebreak=1, wen=0; trap_done=1 for exactly one cycle.
REQ-023 RV64=0, XLEN=32, addiw 32'h0010009b -> out_illegal=1, wen=0, imm=0; same with RV64=1 -> legal, imm=1.
REQ-024 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no trap_done.
REQ-025 rst_n asserted asynchronously mid-cycle with both entries full -> out_valid=0 immediately, not waiting for clk.

Source files
------------

// File: rtl/ysyx_220053_decode_stage.sv
// Decode stage: combinational RISC-V field/immediate decode of the incoming word,
// registered into a two-entry (output + skid) buffer with valid/ready handshakes.
module ysyx_220053_decode_stage #(
    parameter int unsigned XLEN = 64,
    parameter bit          RV64 = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [2:0]      out_ext_op,
    output logic [XLEN-1:0] out_imm,
    output logic            out_wen,
    output logic            out_ebreak,
    output logic            out_illegal,
    output logic            trap_done
);

    localparam logic [2:0] ExtI = 3'd0;
    localparam logic [2:0] ExtU = 3'd1;
    localparam logic [2:0] ExtS = 3'd2;
    localparam logic [2:0] ExtB = 3'd3;
    localparam logic [2:0] ExtJ = 3'd4;
    localparam logic [2:0] ExtR = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [2:0]      ext_op;
        logic [XLEN-1:0] imm;
        logic            wen;
        logic            ebreak;
        logic            illegal;
    } entry_t;

    entry_t dec;
    entry_t out_q, out_d, skid_q, skid_d;
    logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic   trap_q, trap_d;
    logic   accept, leave;

    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic signed [31:0] imm_s;

    assign opcode = in_instr[6:0];
    assign func3  = in_instr[14:12];

    // Opcode table: select immediate format, rd write enable and legality.
    always_comb begin
        dec.pc      = in_pc;
        dec.instr   = in_instr;
        dec.ext_op  = ExtR;
        dec.wen     = 1'b0;
        dec.ebreak  = 1'b0;
        dec.illegal = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111: begin dec.ext_op = ExtU; dec.wen = 1'b1; end
            7'b1101111: begin dec.ext_op = ExtJ; dec.wen = 1'b1; end
            7'b1100111: begin
                if (func3 == 3'b000) begin dec.ext_op = ExtI; dec.wen = 1'b1; end
                else dec.illegal = 1'b1;
            end
            7'b1100011: begin
                if (func3 == 3'b010 || func3 == 3'b011) dec.illegal = 1'b1;
                else dec.ext_op = ExtB;
            end
            7'b0000011: begin
                if (func3 == 3'b111) dec.illegal = 1'b1;
                else begin dec.ext_op = ExtI; dec.wen = 1'b1; end
            end
            7'b0100011: begin
                if (func3 > 3'b011) dec.illegal = 1'b1;
                else dec.ext_op = ExtS;
            end
            7'b0010011: begin dec.ext_op = ExtI; dec.wen = 1'b1; end
            7'b0110011: begin dec.ext_op = ExtR; dec.wen = 1'b1; end
            7'b0011011: begin
                if (RV64) begin dec.ext_op = ExtI; dec.wen = 1'b1; end
                else dec.illegal = 1'b1;
            end
            7'b0111011: begin
                if (RV64) begin dec.ext_op = ExtR; dec.wen = 1'b1; end
                else dec.illegal = 1'b1;
            end
            7'b1110011: begin
                // Only ebreak is supported; its I-format immediate field is 1.
                if (in_instr == 32'h0010_0073) begin dec.ext_op = ExtI; dec.ebreak = 1'b1; end
                else dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Immediate assembly per format; illegal entries keep ext_op=R so imm is zero.
    always_comb begin
        imm_s = '0;
        case (dec.ext_op)
            ExtI: imm_s = {{20{in_instr[31]}}, in_instr[31:20]};
            ExtU: imm_s = {in_instr[31:12], 12'b0};
            ExtS: imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            ExtB: imm_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            ExtJ: imm_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            default: imm_s = '0;
        endcase
        dec.imm = XLEN'(imm_s);
    end

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign leave    = out_valid_q && out_ready;

    // Buffer next-state: output register refills from skid first to keep FIFO order.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        trap_d       = leave && out_q.ebreak && !flush;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || leave) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            trap_q       <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            trap_q       <= trap_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign out_op      = out_q.instr[6:0];
    assign out_rd      = out_q.instr[11:7];
    assign out_func3   = out_q.instr[14:12];
    assign out_rs1     = out_q.instr[19:15];
    assign out_rs2     = out_q.instr[24:20];
    assign out_func7   = out_q.instr[31:25];
    assign out_ext_op  = out_q.ext_op;
    assign out_imm     = out_q.imm;
    assign out_wen     = out_q.wen;
    assign out_ebreak  = out_q.ebreak;
    assign out_illegal = out_q.illegal;
    assign trap_done   = trap_q;

endmodule
